// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer: 16/16 unsigned restoring divider. It borrows the shared
// combinational ALU, which runs one SUB per iteration, and reports quotient,
// remainder and a status byte laid out the same way as the ALU status.
module alu_div_sequencer #(
  parameter logic [5:0]  SUB_OP  = 6'b010011,
  parameter logic [5:0]  IDLE_OP = 6'b000000,
  parameter int unsigned ITERS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic [7:0]  status_out,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [5:0]  alu_opcode,
  output logic [15:0] alu_rs1,
  output logic [15:0] alu_rs2,
  input  logic [15:0] alu_result,
  input  logic        alu_carry
);

  localparam int unsigned CW = $clog2(ITERS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [15:0]   q_reg;
  logic [15:0]   r_reg;
  logic [15:0]   d_reg;
  logic [CW-1:0] count;
  logic          div_zero;

  // Results shown outside the done cycle; refreshed only when a done pulse
  // completes, so an abort leaves the previous result visible.
  logic [15:0]   quotient_hold;
  logic [15:0]   remainder_hold;
  logic [7:0]    status_hold;

  logic [15:0]   shifted_rem;
  logic [7:0]    status_calc;
  logic          last_iter;

  // Shifted partial remainder and status derived from the working registers
  always_comb begin
    shifted_rem = {r_reg[14:0], q_reg[15]};
    last_iter   = (count == CW'(ITERS - 1));
    status_calc = {(q_reg == 16'h0000), q_reg[15], 1'b0, 1'b0,
                   div_zero, q_reg[15] ^ div_zero, 1'b1, 1'b0};
  end

  // Control state: abort beats start, grant and the iteration step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= (divisor != 16'h0000) ? RUN : DONE;
          end
        end
        RUN: begin
          if (alu_gnt && last_iter) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Working registers: operand latch on start, one restoring step per grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= 16'h0000;
      r_reg    <= 16'h0000;
      d_reg    <= 16'h0000;
      count    <= '0;
      div_zero <= 1'b0;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        count <= '0;
        d_reg <= divisor;
        if (divisor != 16'h0000) begin
          q_reg    <= dividend;
          r_reg    <= 16'h0000;
          div_zero <= 1'b0;
        end else begin
          q_reg    <= 16'hFFFF;
          r_reg    <= dividend;
          div_zero <= 1'b1;
        end
      end else if (state == RUN && alu_gnt) begin
        // Carry set means no borrow: the trial subtraction is kept
        r_reg <= alu_carry ? alu_result : shifted_rem;
        q_reg <= {q_reg[14:0], alu_carry};
        count <= count + CW'(1);
      end
    end
  end

  // Result hold registers, loaded as a non-aborted done cycle ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_hold  <= 16'h0000;
      remainder_hold <= 16'h0000;
      status_hold    <= 8'h00;
    end else if (state == DONE && !abort) begin
      quotient_hold  <= q_reg;
      remainder_hold <= r_reg;
      status_hold    <= status_calc;
    end
  end

  // Outputs: ALU drive depends on state only, never on alu_gnt
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE) && !abort;
    alu_req    = (state == RUN);
    alu_opcode = alu_req ? SUB_OP : IDLE_OP;
    alu_rs1    = alu_req ? shifted_rem : 16'h0000;
    alu_rs2    = alu_req ? d_reg : 16'h0000;
    quotient   = done ? q_reg : quotient_hold;
    remainder  = done ? r_reg : remainder_hold;
    status_out = done ? status_calc : status_hold;
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// tb_alu_div_sequencer: directed vectors against alu_div_sequencer with a
// behavioural ALU and a grant generator that can stall in a 0,0,1 pattern.
module tb_alu_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic [7:0]  status_out;
  logic        alu_req;
  logic        alu_gnt;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_rs1;
  logic [15:0] alu_rs2;
  logic [15:0] alu_result;
  logic        alu_carry;

  int n_vec  = 0;
  int n_fail = 0;

  logic        gnt_mode;
  logic [1:0]  ph;
  logic [16:0] sum;

  alu_div_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .status_out (status_out),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_opcode (alu_opcode),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: SUB is rs1 + ~rs2 + 1 with carry out of bit 16
  assign sum        = {1'b0, alu_rs1} + {1'b0, ~alu_rs2} + 17'd1;
  assign alu_result = sum[15:0];
  assign alu_carry  = (alu_opcode == 6'b010011) ? sum[16] : 1'b0;

  // Grant phase restarts whenever the request drops
  always @(posedge clk) begin
    if (!alu_req) ph <= 2'd0;
    else          ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
  end
  assign alu_gnt = gnt_mode ? (alu_req && ph == 2'd2) : 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a negedge; returns just after the negedge where done
  // was seen, busy fell, or the cycle budget ran out.
  task automatic run_div(input logic [15:0] dvd, input logic [15:0] dvs,
                         input int abort_at, input int start_at,
                         output int cyc, output bit got_done, output bit saw_req);
    logic [15:0] mr, mq, md, t;
    int   mc;
    bit   g, ab_now, aborted;
    got_done = 0;
    saw_req  = 0;
    aborted  = 0;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    mr = 16'h0; mq = dvd; md = dvs; mc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
        break;
      end
      if (alu_req) saw_req = 1;
      if (!busy) break;
      if (alu_req) begin
        check_eq("alu_rs1", {16'h0, alu_rs1}, {16'h0, mr[14:0], mq[15]});
        check_eq("alu_rs2", {16'h0, alu_rs2}, {16'h0, md});
      end
      ab_now = 0;
      if (abort_at >= 0 && mc == abort_at && !aborted) begin
        abort   = 1'b1;
        ab_now  = 1;
        aborted = 1;
      end
      if (start_at == k) begin
        start    = 1'b1;
        dividend = 16'hBEEF;
        divisor  = 16'h0003;
      end
      g = alu_gnt;
      @(posedge clk);
      cyc++;
      if (!ab_now && g && alu_req) begin
        t = {mr[14:0], mq[15]};
        if (t >= md) begin
          mr = t - md;
          mq = {mq[14:0], 1'b1};
        end else begin
          mr = t;
          mq = {mq[14:0], 1'b0};
        end
        mc++;
      end
      #1;
      abort = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                              input logic [7:0] st);
    check_eq({tag, "_q"}, {16'h0, quotient}, {16'h0, q});
    check_eq({tag, "_r"}, {16'h0, remainder}, {16'h0, r});
    check_eq({tag, "_st"}, {24'h0, status_out}, {24'h0, st});
  endtask

  int cyc;
  bit got_done, saw_req;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    dividend = 16'h0; divisor = 16'h0; gnt_mode = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_req", {31'h0, alu_req}, 32'h0);
    check_eq("rst_op", {26'h0, alu_opcode}, 32'h0);
    check_eq("rst_rs", {alu_rs1, alu_rs2}, 32'h0);
    check_result("rst", 16'h0, 16'h0, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7 with continuous grant
    run_div(16'd100, 16'd7, -1, -1, cyc, got_done, saw_req);
    check_eq("d1_done", {31'h0, got_done}, 32'h1);
    check_eq("d1_lat", cyc, 17);
    check_result("d1", 16'd14, 16'd2, 8'h02);
    @(negedge clk);
    check_eq("d1_pulse", {31'h0, done}, 32'h0);
    check_eq("d1_op_idle", {26'h0, alu_opcode}, 32'h0);
    check_result("d1_hold", 16'd14, 16'd2, 8'h02);

    // Boundaries: large quotient, zero quotient
    run_div(16'hFFFF, 16'd1, -1, -1, cyc, got_done, saw_req);
    check_eq("d2_done", {31'h0, got_done}, 32'h1);
    check_result("d2", 16'hFFFF, 16'h0, 8'h46);
    @(negedge clk);
    run_div(16'hFFFE, 16'hFFFF, -1, -1, cyc, got_done, saw_req);
    check_eq("d3_done", {31'h0, got_done}, 32'h1);
    check_result("d3", 16'h0, 16'hFFFE, 8'h82);
    @(negedge clk);

    // Divide by zero
    run_div(16'h1234, 16'h0, -1, -1, cyc, got_done, saw_req);
    check_eq("dz_done", {31'h0, got_done}, 32'h1);
    check_eq("dz_lat", cyc, 1);
    check_eq("dz_noreq", {31'h0, saw_req}, 32'h0);
    check_result("dz", 16'hFFFF, 16'h1234, 8'h4A);
    @(negedge clk);
    check_result("dz_hold", 16'hFFFF, 16'h1234, 8'h4A);

    // 1000 / 33 with grant pattern 0,0,1
    gnt_mode = 1'b1;
    run_div(16'd1000, 16'd33, -1, -1, cyc, got_done, saw_req);
    check_eq("st_done", {31'h0, got_done}, 32'h1);
    check_eq("st_lat", cyc, 49);
    check_result("st", 16'd30, 16'd10, 8'h02);
    gnt_mode = 1'b0;
    @(negedge clk);

    // Abort after five iterations of 100 / 7
    run_div(16'd100, 16'd7, 5, -1, cyc, got_done, saw_req);
    check_eq("ab_nodone", {31'h0, got_done}, 32'h0);
    check_eq("ab_busy", {31'h0, busy}, 32'h0);
    check_eq("ab_req", {31'h0, alu_req}, 32'h0);
    check_result("ab_keep", 16'd30, 16'd10, 8'h02);
    @(negedge clk);
    check_eq("ab_pulse", {31'h0, done}, 32'h0);
    run_div(16'd100, 16'd7, -1, -1, cyc, got_done, saw_req);
    check_eq("ab_re_done", {31'h0, got_done}, 32'h1);
    check_eq("ab_re_lat", cyc, 17);
    check_result("ab_re", 16'd14, 16'd2, 8'h02);
    @(negedge clk);

    // Start pulsed while busy is ignored
    run_div(16'd1000, 16'd33, -1, 4, cyc, got_done, saw_req);
    check_eq("sb_done", {31'h0, got_done}, 32'h1);
    check_eq("sb_lat", cyc, 17);
    check_result("sb", 16'd30, 16'd10, 8'h02);
    @(negedge clk);

    // Reset mid-run
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mr_busy", {31'h0, busy}, 32'h0);
    check_eq("mr_req", {31'h0, alu_req}, 32'h0);
    check_eq("mr_rs", {alu_rs1, alu_rs2}, 32'h0);
    check_result("mr", 16'h0, 16'h0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) begin
        check_eq("mr_quiet", {30'h0, done, busy}, 32'h0);
        break;
      end
    end
    check_result("mr_after", 16'h0, 16'h0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_div_sequencer.md
Name: alu_div_sequencer

Overview:
- Multi-cycle controller that performs a 16/16 unsigned divide by sequencing the shared combinational ALU through 16 SUB operations, using restoring division.
- Sits beside the execute stage. Borrows the ALU through a request/grant pair, because the CPU execute stage has priority on the ALU.
- Returns quotient, remainder and a status byte in the same bit layout the ALU uses for status.

Parameters:
- SUB_OP, 6'b010011, encoded opcode driven for each iteration (ALU SUB: rs1 + ~rs2 + 1, 17-bit).
- IDLE_OP, 6'b000000, opcode driven whenever alu_req is low.
- ITERS, 16, number of iterations. Fixed at the ALU data width; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a divide.
- abort  in  1  synchronous cancel.
- dividend  in  16  numerator, sampled when start is accepted.
- divisor  in  16  denominator, sampled when start is accepted.
- busy  out  1  high from accepted start until done, or until abort.
- done  out  1  one-cycle pulse; quotient, remainder and status_out are valid and held afterwards.
- quotient  out  16  result.
- remainder  out  16  result.
- status_out  out  8  {Z, N, C, 0, V, S, 1, 0}; see Behaviour.
- alu_req  out  1  requests the ALU for this cycle.
- alu_gnt  in  1  ALU granted this cycle.
- alu_opcode  out  6  ALU opcode.
- alu_rs1  out  16  ALU operand 1.
- alu_rs2  out  16  ALU operand 2.
- alu_result  in  16  ALU result, same cycle (combinational path).
- alu_carry  in  1  ALU bit 16 of the sum; 1 means no borrow.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; busy, done, alu_req = 0; quotient, remainder, status_out = 0; alu_opcode = IDLE_OP; alu_rs1, alu_rs2 = 0; internal count = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with divisor≠0: latch D=divisor, Q=dividend, R=0, count=0; go to RUN.
  - start=1 with divisor=0: go to DONE with quotient=16'hFFFF, remainder=dividend, V=1.
  - start is ignored in every state except IDLE.
- RUN: alu_req=1, alu_opcode=SUB_OP, alu_rs1={R[14:0],Q[15]}, alu_rs2=D. The shifted remainder never exceeds 16 bits, since R<2^15 before the last shift.
- Edge with alu_gnt=1:
  - alu_carry=1: R←alu_result, Q←{Q[14:0],1}.
  - alu_carry=0: R←alu_rs1, Q←{Q[14:0],0}.
  - count←count+1; after the 16th iteration go to DONE.
- Edge with alu_gnt=0: no state change (stall). Operands stay stable while stalled. Any number of stall cycles is allowed.
- DONE: done=1 for exactly one cycle; quotient=Q, remainder=R; go to IDLE.
- busy is high in RUN and DONE.
- Outputs hold their values until the next accepted start.
- Latency with continuous grant: start accepted at edge 0; done high in the cycle after edge 16, i.e. 17 cycles. Divide-by-zero: done high in the cycle after edge 0.
- status_out:
  - Z = (quotient==0).
  - N = quotient[15].
  - C = 0.
  - V = div-by-zero.
  - S = N^V.
  - bit1 = 1.
  - bit0 = 0.
- abort=1 in RUN or DONE: next state IDLE; no done pulse; quotient, remainder and status_out keep their previous values; alu_req drops next cycle.
- abort has priority over grant and over the iteration step.
- start and abort both high in IDLE: abort wins, start is dropped.
- rst asserted mid-operation: immediate return to reset values; no done pulse.
- alu_rs1, alu_rs2 and alu_opcode are registered or derived from state only; they never depend combinationally on alu_gnt.

Test Plan:
- dividend=100, divisor=7, alu_gnt tied 1 -> done exactly 17 cycles after start; quotient=14, remainder=2, Z=0.
- dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0, N=1, S=1; divisor=16'hFFFF, dividend=16'hFFFE -> quotient=0, remainder=16'hFFFE, Z=1.
- divisor=0, dividend=16'h1234 -> done 1 cycle after start; quotient=16'hFFFF, remainder=16'h1234, V=1, S=0; no alu_req ever asserted.
- 1000/33 with alu_gnt toggling 0,0,1 repeating -> done 49 cycles after start; quotient=30, remainder=10; operands stable in every stalled cycle.
- abort asserted at iteration 5 of 100/7 -> no done pulse, busy=0 next cycle, outputs retain the previous result; a fresh start runs correctly.
- rst pulsed mid-run; start pulsed while busy -> all outputs return to reset values; the start is ignored and the original operation result is unchanged.
